// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two valid/ready requesters.
// Exactly one operation is in flight: IDLE grants, EXEC captures ALU_OUT, RESP holds the result until taken.
module alu_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_k,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_k,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [1:0]       ALU_K,
  input  logic [WIDTH-1:0] ALU_OUT,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic             rr_ptr_r;
  logic             owner_r;
  logic [WIDTH-1:0] op_a_r;
  logic [WIDTH-1:0] op_b_r;
  logic [1:0]       op_k_r;
  logic [WIDTH-1:0] result_r;
  logic             grant_any_s;
  logic             grant_sel_s;
  logic             rsp_hs_s;

  // Grant decision: only in IDLE; rr_ptr breaks ties when both requesters are valid.
  always_comb begin
    grant_any_s = 1'b0;
    grant_sel_s = 1'b0;
    if (state_r == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_any_s = 1'b1;
        grant_sel_s = rr_ptr_r;
      end else if (req0_valid) begin
        grant_any_s = 1'b1;
        grant_sel_s = 1'b0;
      end else if (req1_valid) begin
        grant_any_s = 1'b1;
        grant_sel_s = 1'b1;
      end else begin
        grant_any_s = 1'b0;
        grant_sel_s = 1'b0;
      end
    end else begin
      grant_any_s = 1'b0;
      grant_sel_s = 1'b0;
    end
  end

  assign rsp_hs_s = (state_r == RESP) && (owner_r ? rsp1_ready : rsp0_ready);

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (grant_any_s) state_nxt_s = EXEC; else state_nxt_s = IDLE;
      EXEC:    state_nxt_s = RESP;
      RESP:    if (rsp_hs_s) state_nxt_s = IDLE; else state_nxt_s = RESP;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Operand capture, result capture and round-robin pointer update.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rr_ptr_r <= 1'b0;
      owner_r  <= 1'b0;
      op_a_r   <= {WIDTH{1'b0}};
      op_b_r   <= {WIDTH{1'b0}};
      op_k_r   <= 2'b00;
      result_r <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_any_s) begin
            owner_r <= grant_sel_s;
            op_a_r  <= grant_sel_s ? req1_a : req0_a;
            op_b_r  <= grant_sel_s ? req1_b : req0_b;
            op_k_r  <= grant_sel_s ? req1_k : req0_k;
          end
        end
        EXEC: result_r <= ALU_OUT;
        RESP: begin
          // The pointer moves only when a response completes, never on a lone grant.
          if (rsp_hs_s) rr_ptr_r <= ~owner_r;
        end
        default: ;
      endcase
    end
  end

  // Output decode from state and owner; data comes straight from registers.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp0_data  = {WIDTH{1'b0}};
    rsp1_data  = {WIDTH{1'b0}};
    case (state_r)
      IDLE: begin
        req0_ready = grant_any_s && !grant_sel_s;
        req1_ready = grant_any_s && grant_sel_s;
      end
      RESP: begin
        if (owner_r) begin
          rsp1_valid = 1'b1;
          rsp1_data  = result_r;
        end else begin
          rsp0_valid = 1'b1;
          rsp0_data  = result_r;
        end
      end
      default: ;
    endcase
  end

  assign ALU_A = op_a_r;
  assign ALU_B = op_b_r;
  assign ALU_K = op_k_r;
  assign busy  = (state_r != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural model of the shared ALU.
module tb_alu_arbiter;
  logic        Clk = 1'b0;
  logic        Reset;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b, rsp0_data, rsp1_data;
  logic [1:0]  req0_k, req1_k, ALU_K;
  logic [15:0] ALU_A, ALU_B, ALU_OUT;
  logic        busy;
  int checks = 0;
  int errors = 0;

  alu_arbiter #(.WIDTH(16)) dut (
    .Clk(Clk), .Reset(Reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_k(req0_k),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_k(req1_k),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_K(ALU_K), .ALU_OUT(ALU_OUT), .busy(busy)
  );

  always #5 Clk = ~Clk;

  // Team ALU model: ADD, AND, NOT, and 0 for the unused opcode.
  always_comb begin
    case (ALU_K)
      2'b00:   ALU_OUT = ALU_A + ALU_B;
      2'b01:   ALU_OUT = ALU_A & ALU_B;
      2'b10:   ALU_OUT = ~ALU_A;
      default: ALU_OUT = 16'h0000;
    endcase
  end

  task automatic test_reset();
    Reset = 1'b1;
    req0_valid = 1'b0; req0_a = 16'h0000; req0_b = 16'h0000; req0_k = 2'b00; rsp0_ready = 1'b0;
    req1_valid = 1'b0; req1_a = 16'h0000; req1_b = 16'h0000; req1_k = 2'b00; rsp1_ready = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if ({ALU_A, ALU_B, ALU_K} !== 34'h0) begin errors++; $display("FAIL reset_alu: got %h %h %b expected 0 0 00", ALU_A, ALU_B, ALU_K); end
    checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", {rsp0_valid, rsp1_valid}); end
    checks++; if ({rsp0_data, rsp1_data} !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h %h expected 0 0", rsp0_data, rsp1_data); end
    Reset = 1'b0;
  endtask

  task automatic test_single();
    @(negedge Clk);
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h0FF0; req0_k = 2'b00; rsp0_ready = 1'b1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready: got %b expected 10", {req0_ready, req1_ready}); end
    @(posedge Clk); @(negedge Clk);
    req0_valid = 1'b0;
    checks++; if ({busy, rsp0_valid, rsp1_valid} !== 3'b100) begin errors++; $display("FAIL single_exec_flags: got %b expected 100", {busy, rsp0_valid, rsp1_valid}); end
    checks++; if ({ALU_A, ALU_B, ALU_K} !== {16'h1234, 16'h0FF0, 2'b00}) begin errors++; $display("FAIL single_alu_ops: got %h %h %b expected 1234 0ff0 00", ALU_A, ALU_B, ALU_K); end
    @(posedge Clk); @(negedge Clk);
    checks++; if ({rsp0_valid, rsp1_valid} !== 2'b10) begin errors++; $display("FAIL single_rsp_valid: got %b expected 10", {rsp0_valid, rsp1_valid}); end
    checks++; if (rsp0_data !== 16'h2224) begin errors++; $display("FAIL single_rsp_data: got %h expected 2224", rsp0_data); end
    @(posedge Clk); @(negedge Clk);
    checks++; if ({busy, rsp0_valid, rsp1_valid} !== 3'b000) begin errors++; $display("FAIL single_done: got %b expected 000", {busy, rsp0_valid, rsp1_valid}); end
  endtask

  task automatic test_opcodes();
    logic [15:0] ta [4];
    logic [15:0] tb [4];
    logic [1:0]  tk [4];
    logic [15:0] te [4];
    ta = '{16'hF0F0, 16'h00FF, 16'hFFFF, 16'hABCD};
    tb = '{16'h3C3C, 16'h1234, 16'h0001, 16'h1111};
    tk = '{2'b01, 2'b10, 2'b00, 2'b11};
    te = '{16'h3030, 16'hFF00, 16'h0000, 16'h0000};
    rsp1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      req1_valid = 1'b1; req1_a = ta[i]; req1_b = tb[i]; req1_k = tk[i];
      #1;
      checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL op%0d_ready: got %b expected 01", i, {req0_ready, req1_ready}); end
      @(posedge Clk); @(negedge Clk);
      req1_valid = 1'b0;
      checks++; if (ALU_K !== tk[i]) begin errors++; $display("FAIL op%0d_aluk: got %b expected %b", i, ALU_K, tk[i]); end
      @(posedge Clk); @(negedge Clk);
      checks++; if ({rsp0_valid, rsp1_valid} !== 2'b01) begin errors++; $display("FAIL op%0d_rsp_valid: got %b expected 01", i, {rsp0_valid, rsp1_valid}); end
      checks++; if (rsp1_data !== te[i]) begin errors++; $display("FAIL op%0d_rsp_data: got %h expected %h", i, rsp1_data, te[i]); end
      @(posedge Clk);
    end
  endtask

  task automatic test_contention();
    logic [15:0] a0 [3]; logic [15:0] b0 [3]; logic [1:0] k0 [3]; logic [15:0] e0 [3];
    logic [15:0] a1 [3]; logic [15:0] b1 [3]; logic [1:0] k1 [3]; logic [15:0] e1 [3];
    logic [15:0] exp_d;
    int p0, p1, sel;
    a0 = '{16'h1000, 16'hFF00, 16'h5555}; b0 = '{16'h0234, 16'h0FF0, 16'h0000};
    k0 = '{2'b00, 2'b01, 2'b10};          e0 = '{16'h1234, 16'h0F00, 16'hAAAA};
    a1 = '{16'h0001, 16'h8000, 16'h1234}; b1 = '{16'h0002, 16'h8000, 16'hFFFF};
    k1 = '{2'b00, 2'b00, 2'b01};          e1 = '{16'h0003, 16'h0000, 16'h1234};
    p0 = 0; p1 = 0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(negedge Clk);
    req0_valid = 1'b1; req0_a = a0[0]; req0_b = b0[0]; req0_k = k0[0];
    req1_valid = 1'b1; req1_a = a1[0]; req1_b = b1[0]; req1_k = k1[0];
    for (int i = 0; i < 6; i++) begin
      sel = i % 2;
      #1;
      checks++; if ({req0_ready, req1_ready} !== ((sel == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL cont%0d_grant: got %b expected requester %0d", i, {req0_ready, req1_ready}, sel); end
      @(posedge Clk); @(negedge Clk);
      if (sel == 0) begin
        exp_d = e0[p0]; p0++;
        if (p0 < 3) begin req0_a = a0[p0]; req0_b = b0[p0]; req0_k = k0[p0]; end else req0_valid = 1'b0;
      end else begin
        exp_d = e1[p1]; p1++;
        if (p1 < 3) begin req1_a = a1[p1]; req1_b = b1[p1]; req1_k = k1[p1]; end else req1_valid = 1'b0;
      end
      @(posedge Clk); @(negedge Clk);
      checks++; if ({rsp0_valid, rsp1_valid} !== ((sel == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL cont%0d_rsp_valid: got %b expected requester %0d", i, {rsp0_valid, rsp1_valid}, sel); end
      checks++; if (((sel == 0) ? rsp0_data : rsp1_data) !== exp_d) begin errors++; $display("FAIL cont%0d_rsp_data: got %h expected %h", i, (sel == 0) ? rsp0_data : rsp1_data, exp_d); end
      @(posedge Clk); @(negedge Clk);
    end
  endtask

  task automatic test_backpressure();
    req0_valid = 1'b1; req0_a = 16'h0003; req0_b = 16'h0004; req0_k = 2'b00; rsp0_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h00FF; req1_b = 16'h0F0F; req1_k = 2'b01; rsp1_ready = 1'b1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL bp_grant0: got %b expected 10", {req0_ready, req1_ready}); end
    @(posedge Clk); @(negedge Clk);
    req0_valid = 1'b0;
    @(posedge Clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      checks++; if ({rsp0_valid, rsp1_valid, req1_ready, busy} !== 4'b1001) begin errors++; $display("FAIL bp_hold%0d_flags: got %b expected 1001", i, {rsp0_valid, rsp1_valid, req1_ready, busy}); end
      checks++; if (rsp0_data !== 16'h0007) begin errors++; $display("FAIL bp_hold%0d_data: got %h expected 0007", i, rsp0_data); end
      @(posedge Clk);
    end
    @(negedge Clk);
    rsp0_ready = 1'b1;
    @(posedge Clk); @(negedge Clk);
    checks++; if ({busy, req0_ready, req1_ready} !== 3'b001) begin errors++; $display("FAIL bp_grant1: got %b expected 001", {busy, req0_ready, req1_ready}); end
    @(posedge Clk); @(negedge Clk);
    req1_valid = 1'b0;
    @(posedge Clk); @(negedge Clk);
    checks++; if ({rsp0_valid, rsp1_valid, rsp1_data} !== {2'b01, 16'h000F}) begin errors++; $display("FAIL bp_rsp1: got %b %b %h expected 0 1 000f", rsp0_valid, rsp1_valid, rsp1_data); end
    @(posedge Clk); @(negedge Clk);
  endtask

  task automatic test_reset_mid();
    // Complete a lone requester-0 op so the pointer favours requester 1 before reset.
    req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0001; req0_k = 2'b00; rsp0_ready = 1'b1;
    @(posedge Clk); @(negedge Clk);
    req0_valid = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    req1_valid = 1'b1; req1_a = 16'hFFFF; req1_b = 16'hFFFF; req1_k = 2'b01; rsp1_ready = 1'b1;
    @(posedge Clk); @(negedge Clk);
    req1_valid = 1'b0;
    checks++; if ({busy, ALU_A} !== {1'b1, 16'hFFFF}) begin errors++; $display("FAIL rst_mid_exec: got %b %h expected 1 ffff", busy, ALU_A); end
    Reset = 1'b1;
    @(posedge Clk); @(negedge Clk);
    Reset = 1'b0;
    checks++; if ({busy, rsp0_valid, rsp1_valid} !== 3'b000) begin errors++; $display("FAIL rst_mid_flags: got %b expected 000", {busy, rsp0_valid, rsp1_valid}); end
    checks++; if ({ALU_A, ALU_B, ALU_K} !== 34'h0) begin errors++; $display("FAIL rst_mid_alu: got %h %h %b expected 0 0 00", ALU_A, ALU_B, ALU_K); end
    req0_valid = 1'b1; req0_a = 16'h0002; req0_b = 16'h0003; req0_k = 2'b00;
    req1_valid = 1'b1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL rst_mid_rrptr: got %b expected 10", {req0_ready, req1_ready}); end
    @(posedge Clk); @(negedge Clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge Clk); @(negedge Clk);
    checks++; if ({rsp0_valid, rsp1_valid, rsp0_data} !== {2'b10, 16'h0005}) begin errors++; $display("FAIL rst_mid_after: got %b %b %h expected 1 0 0005", rsp0_valid, rsp1_valid, rsp0_data); end
    @(posedge Clk); @(negedge Clk);
  endtask

  task automatic test_withdraw();
    req0_valid = 1'b1; req0_a = 16'h0010; req0_b = 16'h0020; req0_k = 2'b00; rsp0_ready = 1'b1;
    @(posedge Clk); @(negedge Clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h4444; req1_b = 16'h0000; req1_k = 2'b10;
    #1;
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL wd_exec_ready: got %b expected 0", req1_ready); end
    @(posedge Clk); @(negedge Clk);
    checks++; if ({req1_ready, rsp0_valid, rsp0_data} !== {2'b01, 16'h0030}) begin errors++; $display("FAIL wd_resp: got %b %b %h expected 0 1 0030", req1_ready, rsp0_valid, rsp0_data); end
    req1_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); @(negedge Clk);
      checks++; if ({busy, rsp1_valid, req1_ready} !== 3'b000) begin errors++; $display("FAIL wd_idle%0d: got %b expected 000", i, {busy, rsp1_valid, req1_ready}); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_opcodes();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_withdraw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 16-bit ALU between two requesters. Supported ops: ADD=2'b00, AND=2'b01, NOT=2'b10.
- Each requester has a valid/ready request channel (A, B, ALUK) and a valid/ready response channel.
- Arbitration is round-robin. Exactly one operation is in flight at a time.
- Sits between datapath clients (e.g. the CPU execute stage and a DMA/checksum unit) and the shared ALU instance. The ALU itself is instantiated outside this block.

Parameters:
- WIDTH, 16, operand/result width in bits.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  WIDTH  operand A, requester 0.
- req0_b  in  WIDTH  operand B, requester 0.
- req0_k  in  2  ALUK opcode, requester 0.
- rsp0_valid  out  1  result available for requester 0.
- rsp0_ready  in  1  requester 0 takes the result.
- rsp0_data  out  WIDTH  result for requester 0.
- req1_valid, req1_ready, req1_a, req1_b, req1_k, rsp1_valid, rsp1_ready, rsp1_data: identical set for requester 1.
- ALU_A  out  WIDTH  operand A to the shared ALU.
- ALU_B  out  WIDTH  operand B to the shared ALU.
- ALU_K  out  2  opcode to the shared ALU.
- ALU_OUT  in  WIDTH  combinational result from the shared ALU.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clocking/reset: one clock, Clk. Reset is synchronous and active-high.
- Reset values (applied on any edge with Reset=1, including mid-operation):
  - state=IDLE, rr_ptr=0 (requester 0 has priority).
  - Operand regs, opcode reg and result reg = 0, so ALU_A=ALU_B=0 and ALU_K=0.
  - rsp0_valid=rsp1_valid=0, rsp data=0, busy=0.
  - Any in-flight operation is discarded and produces no response.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req*_ready are combinational and asserted only in IDLE.
  - Only one valid: grant it.
  - Both valid: grant the requester indicated by rr_ptr.
  - Granted reqN_ready=1 in the same cycle; the other ready=0.
  - On the edge: latch a/b/k into operand regs, owner<=N, go to EXEC.
  - No valid: stay in IDLE.
- EXEC:
  - ALU_A/ALU_B/ALU_K are driven from the operand regs (registered; stable for the whole operation).
  - On the edge: result<=ALU_OUT, go to RESP.
- RESP:
  - rsp<owner>_valid=1 and rsp<owner>_data=result, held stable until handshake. The other rsp_valid stays 0.
  - On an edge with rsp<owner>_ready=1: go to IDLE, rr_ptr<=~owner.
  - Otherwise remain in RESP. Backpressure is unlimited and no new request is accepted.
- Latency and throughput:
  - Request accept to rsp_valid = 2 cycles.
  - With rsp_ready held high, minimum request-to-request spacing per arbiter = 3 cycles.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1 starting with 0 after reset.
- A requester granted alone does not change who wins the next conflict except through rr_ptr. rr_ptr is updated only on response completion.
- Request handshake rules:
  - Requesters must hold valid and operands until ready.
  - Valid must not depend on ready.
  - Deasserting valid before grant is permitted and simply drops the request.
- Opcode 2'b11 is passed through unchanged. The result is whatever ALU_OUT returns (0 for the team ALU). No error flag.
- Arithmetic: ADD wraps modulo 2^WIDTH; no carry out. The block never alters operands or results.
- Simultaneous events:
  - Response handshake and a new request valid in the same cycle: the request is not accepted until the following IDLE cycle. ready is 0 in RESP.
  - Reset asserted together with a handshake: reset wins.

Test Plan:
- Reset then single op: req0 a=16'h1234, b=16'h0FF0, k=ADD, rsp0_ready=1 -> req0_ready high in accept cycle; 2 cycles later rsp0_valid=1, rsp0_data=16'h2224 for 1 cycle; rsp1_valid never high.
- Opcode coverage via req1: AND 16'hF0F0&16'h3C3C -> 16'h3030; NOT a=16'h00FF -> 16'hFF00; ADD 16'hFFFF+16'h0001 -> 16'h0000 (wrap); k=2'b11 -> 16'h0000.
- Contention: both valid continuously with distinct operands for 6 ops -> grant order 0,1,0,1,0,1; each response routed to the correct port with the correct data.
- Backpressure: rsp0_ready=0 for 5 cycles in RESP -> rsp0_valid and rsp0_data stable, req1_ready stays 0, busy=1; release -> completes, then req1 is granted next IDLE cycle.
- Reset mid-op: assert Reset in EXEC -> next cycle IDLE, no rsp_valid, ALU_A/B/K=0, rr_ptr=0 (req0 wins the next conflict).
- Valid withdrawal: req1_valid pulsed while busy then dropped before IDLE -> never granted, no rsp1_valid.
